rx_fcs_checker: RTL and testbench

- Sits between the OFDM receiver byte output and xpu.
- Consumes the demodulated PSDU byte stream, re-emits it to xpu with a running byte index, and computes IEEE 802.11 CRC-32 over the whole PSDU (FCS included).
- At end of packet, produces the one-cycle fcs_in_strobe/fcs_ok indication xpu uses for ACK and filtering decisions.
- Also guards against truncated or stalled packets with a length check and an inter-byte timeout.

---
 rtl/rx_fcs_checker.sv | 96 +++++++++
 tb/tb_rx_fcs_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rx_fcs_checker.sv
// rx_fcs_checker: forwards PSDU bytes with index, checks CRC-32 residue, flags short/stalled packets
module rx_fcs_checker #(
  parameter int MIN_PKT_LEN    = 5,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pkt_header_valid_strobe,
  input  logic [15:0] pkt_len,
  input  logic        byte_in_strobe,
  input  logic [7:0]  byte_in,
  output logic        byte_out_strobe,
  output logic [7:0]  byte_out,
  output logic [15:0] byte_count,
  output logic        fcs_in_strobe,
  output logic        fcs_ok,
  output logic        pkt_abort,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  logic [1:0]               state;
  logic [15:0]              len_q;
  logic [15:0]              rx_cnt;
  logic [31:0]              crc;
  logic [31:0]              crc_next;
  logic [TIMEOUT_WIDTH-1:0] tmo;
  logic                     short_pend;
  logic                     hdr;
  assign hdr  = pkt_header_valid_strobe && enable;
  assign busy = state != IDLE;
  always_comb begin
    crc_next = crc ^ {24'd0, byte_in};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? (crc_next >> 1) ^ 32'hEDB88320 : crc_next >> 1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      len_q           <= '0;
      rx_cnt          <= '0;
      crc             <= '1;
      tmo             <= '0;
      short_pend      <= 1'b0;
      byte_out_strobe <= 1'b0;
      byte_out        <= '0;
      byte_count      <= '0;
      fcs_in_strobe   <= 1'b0;
      fcs_ok          <= 1'b0;
      pkt_abort       <= 1'b0;
    end else begin
      byte_out_strobe <= 1'b0;
      fcs_in_strobe   <= short_pend;
      fcs_ok          <= 1'b0;
      pkt_abort       <= 1'b0;
      short_pend      <= 1'b0;
      if (state == RECV && !enable) begin
        state <= IDLE;
      end else if (state == RECV && !hdr && byte_in_strobe) begin
        byte_out_strobe <= 1'b1;
        byte_out        <= byte_in;
        byte_count      <= rx_cnt;
        crc             <= crc_next;
        rx_cnt          <= rx_cnt + 16'd1;
        tmo             <= '0;
        if (rx_cnt == len_q - 16'd1) state <= CHECK;
      end else if (state == RECV && !hdr) begin
        if (tmo == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          pkt_abort     <= 1'b1;
          fcs_in_strobe <= 1'b1;
          state         <= IDLE;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else if (state == CHECK) begin
        fcs_in_strobe <= 1'b1;
        fcs_ok        <= crc == 32'hDEBB20E3;
        state         <= IDLE;
      end
      if (hdr && pkt_len >= 16'(MIN_PKT_LEN)) begin
        state  <= RECV;
        len_q  <= pkt_len;
        crc    <= '1;
        rx_cnt <= '0;
        tmo    <= '0;
      end else if (hdr) begin
        state <= IDLE;
        if (state == CHECK || short_pend) short_pend <= 1'b1;
        else fcs_in_strobe <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rx_fcs_checker.sv
// tb_rx_fcs_checker: directed vector bench for rx_fcs_checker
module tb_rx_fcs_checker;
  localparam int T = 4096;
  logic        clock = 1'b0;
  logic        reset, enable, hdr, bs;
  logic [15:0] pkt_len;
  logic [7:0]  bi;
  logic        byte_out_strobe, fcs_in_strobe, fcs_ok, pkt_abort, busy;
  logic [7:0]  byte_out;
  logic [15:0] byte_count;
  rx_fcs_checker #(.MIN_PKT_LEN(5), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(13)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pkt_header_valid_strobe(hdr),
    .pkt_len(pkt_len), .byte_in_strobe(bs), .byte_in(bi),
    .byte_out_strobe(byte_out_strobe), .byte_out(byte_out), .byte_count(byte_count),
    .fcs_in_strobe(fcs_in_strobe), .fcs_ok(fcs_ok), .pkt_abort(pkt_abort), .busy(busy)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [15:0] len;
    int          nb;
    int          kind;
    int          flip;
    logic [7:0]  fv;
    int          gap;
    logic        ok;
    logic        ab;
    int          lat;
  } vec_t;
  typedef struct {
    int   c;
    logic ok;
    logic ab;
  } ev_t;
  logic [7:0] good [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                            8'h26, 8'h39, 8'hF4, 8'hCB};
  logic [7:0] zf [5] = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
  logic [7:0] frame [13];
  vec_t vt [7];
  ev_t  fcs_q [$];
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0, exp_idx = 0, out_cnt = 0, abort_cnt = 0;
  int   hdr_cyc, last_cyc, ref_cyc, o0, a0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic build(input int kind, input int flip, input logic [7:0] fv);
    for (int i = 0; i < 13; i++) frame[i] = kind == 1 ? (i < 5 ? zf[i] : 8'h00) : good[i];
    if (flip >= 0) frame[flip] = fv;
  endtask
  task automatic drive_frame(input logic [15:0] len, input int nb, input int gap, input logic junk);
    hdr = 1'b1;
    pkt_len = len;
    bs = junk;
    bi = 8'hAA;
    hdr_cyc = cyc;
    tick();
    hdr = 1'b0;
    bs = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gap)) tick();
      bs = 1'b1;
      bi = frame[i];
      last_cyc = cyc;
      tick();
      bs = 1'b0;
    end
  endtask
  task automatic wait_fcs(input int n, input int bound);
    for (int i = 0; i < bound && fcs_q.size() < n; i++) tick();
    if (fcs_q.size() < n) chk("fcs_wait_timeout", fcs_q.size(), n);
  endtask
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (byte_out_strobe) begin
      if (exp_idx < 13) begin
        chk("byte_count", byte_count, exp_idx);
        chk("byte_out", byte_out, frame[exp_idx]);
      end else chk("extra_byte_out", exp_idx, 12);
      exp_idx++;
      out_cnt++;
    end
    if (fcs_in_strobe) fcs_q.push_back('{cyc, fcs_ok, pkt_abort});
    if (pkt_abort) abort_cnt++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{16'd13, 13, 0, -1, 8'h00, 0,  1'b1, 1'b0, 2};
    vt[1] = '{16'd13, 13, 0, 4,  8'h34, 0,  1'b0, 1'b0, 2};
    vt[2] = '{16'd13, 13, 0, -1, 8'h00, 20, 1'b1, 1'b0, 2};
    vt[3] = '{16'd3,  0,  0, -1, 8'h00, 0,  1'b0, 1'b0, 1};
    vt[4] = '{16'd4,  0,  0, -1, 8'h00, 0,  1'b0, 1'b0, 1};
    vt[5] = '{16'd5,  5,  1, -1, 8'h00, 3,  1'b1, 1'b0, 2};
    vt[6] = '{16'd13, 6,  0, -1, 8'h00, 0,  1'b0, 1'b1, T + 1};
    reset = 1'b1; enable = 1'b1; hdr = 1'b0; pkt_len = '0; bs = 1'b0; bi = '0;
    build(0, -1, 8'h00);
    repeat (3) tick();
    @(negedge clock);
    chk("reset_outputs", {byte_out_strobe, byte_out, byte_count, fcs_in_strobe, fcs_ok, pkt_abort, busy}, 0);
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      build(vt[k].kind, vt[k].flip, vt[k].fv);
      fcs_q.delete();
      o0 = out_cnt;
      a0 = abort_cnt;
      drive_frame(vt[k].len, vt[k].nb, vt[k].gap, 1'b0);
      ref_cyc = vt[k].nb > 0 ? last_cyc : hdr_cyc;
      wait_fcs(1, vt[k].lat + 10);
      repeat (3) tick();
      chk($sformatf("v%0d_fcs_count", k), fcs_q.size(), 1);
      if (fcs_q.size() > 0) begin
        chk($sformatf("v%0d_fcs_ok", k), fcs_q[0].ok, vt[k].ok);
        chk($sformatf("v%0d_abort", k), fcs_q[0].ab, vt[k].ab);
        chk($sformatf("v%0d_latency", k), fcs_q[0].c - ref_cyc, vt[k].lat);
      end
      chk($sformatf("v%0d_abort_count", k), abort_cnt - a0, vt[k].ab ? 1 : 0);
      chk($sformatf("v%0d_bytes_out", k), out_cnt - o0, vt[k].nb);
      chk($sformatf("v%0d_busy_after", k), busy, 0);
    end
    build(0, -1, 8'h00);
    fcs_q.delete();
    o0 = out_cnt;
    repeat (3) begin
      bs = 1'b1; bi = 8'h55; tick();
    end
    bs = 1'b0;
    repeat (3) tick();
    chk("idle_bytes_dropped", out_cnt - o0, 0);
    chk("idle_no_fcs", fcs_q.size(), 0);
    fcs_q.delete();
    o0 = out_cnt;
    drive_frame(16'd13, 5, 0, 1'b0);
    drive_frame(16'd13, 13, 0, 1'b1);
    wait_fcs(1, 20);
    repeat (5) tick();
    chk("restart_fcs_count", fcs_q.size(), 1);
    if (fcs_q.size() > 0) chk("restart_fcs_ok", fcs_q[0].ok, 1);
    chk("restart_bytes_out", out_cnt - o0, 18);
    fcs_q.delete();
    drive_frame(16'd13, 13, 0, 1'b0);
    drive_frame(16'd13, 13, 0, 1'b0);
    wait_fcs(2, 20);
    repeat (3) tick();
    chk("hdr_in_check_fcs_count", fcs_q.size(), 2);
    if (fcs_q.size() > 1) chk("hdr_in_check_both_ok", {fcs_q[0].ok, fcs_q[1].ok}, 2'b11);
    fcs_q.delete();
    a0 = abort_cnt;
    drive_frame(16'd13, 7, 0, 1'b0);
    reset = 1'b1; bs = 1'b1; bi = frame[7];
    tick();
    reset = 1'b0; bs = 1'b0;
    @(negedge clock);
    chk("midreset_outputs", {byte_out_strobe, byte_out, byte_count, fcs_in_strobe, fcs_ok, pkt_abort, busy}, 0);
    repeat (20) tick();
    chk("midreset_no_fcs", fcs_q.size(), 0);
    drive_frame(16'd13, 13, 0, 1'b0);
    wait_fcs(1, 20);
    repeat (3) tick();
    chk("postreset_fcs_count", fcs_q.size(), 1);
    if (fcs_q.size() > 0) chk("postreset_fcs_ok", fcs_q[0].ok, 1);
    fcs_q.delete();
    o0 = out_cnt;
    drive_frame(16'd13, 5, 0, 1'b0);
    enable = 1'b0;
    tick();
    @(negedge clock);
    chk("disable_busy_low", busy, 0);
    hdr = 1'b1; pkt_len = 16'd3;
    tick();
    hdr = 1'b0;
    repeat (20) tick();
    chk("disable_no_fcs", fcs_q.size(), 0);
    chk("disable_no_abort", abort_cnt - a0, 0);
    chk("disable_bytes_out", out_cnt - o0, 5);
    enable = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
